// File: rtl/hid_key_event_gen.sv
// ============================================================================
// hid_key_event_gen
//
// Purpose:
//   Converts boot-protocol keyboard snapshots from the USB HID host into an
//   ordered stream of per-key make/break events. Each accepted report is
//   diffed against the previously accepted one, one candidate per cycle:
//   eight modifier bits, then six release slots, then six press slots. The
//   resulting events are queued in a first-word-fall-through FIFO.
//
// Ports:
//   clk_48m         system clock
//   rstn            asynchronous active-low reset
//   report_valid    single-cycle strobe, new snapshot on kbd_* inputs
//   kbd_connected   keyboard present; 0 turns the snapshot into "all up"
//   kbd_modifiers   modifier bitmap, bit0 = LCtrl .. bit7 = RGUI
//   kbd_keycodes    six keycodes, slot k = [8k+7:8k]
//   report_busy     diff engine scanning; reports arriving now are dropped
//   report_overrun  sticky flag: a report was dropped (busy or rollover)
//   overrun_clr     single-cycle strobe clearing report_overrun
//   evt_valid       event FIFO non-empty
//   evt_ready       consumer accepts the head event
//   evt_code        HID usage of head event (modifiers map to 0xE0+bit)
//   evt_make        1 = press, 0 = release
//   evt_level       current FIFO occupancy
// ============================================================================
module hid_key_event_gen #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic               clk_48m,
    input  logic               rstn,
    input  logic               report_valid,
    input  logic               kbd_connected,
    input  logic [7:0]         kbd_modifiers,
    input  logic [47:0]        kbd_keycodes,
    output logic               report_busy,
    output logic               report_overrun,
    input  logic               overrun_clr,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [7:0]         evt_code,
    output logic               evt_make,
    output logic [FIFO_AW:0]   evt_level
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOD  = 2'd1,
        S_REL  = 2'd2,
        S_PRS  = 2'd3
    } state_t;

    localparam logic [FIFO_AW:0] DEPTH_L = FIFO_DEPTH[FIFO_AW:0];

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] key_at(input logic [47:0] keys, input logic [2:0] k);
        logic [7:0] r;
        r = 8'h00;
        for (int j = 0; j < 6; j++) begin
            if (int'(k) == j) r = keys[j*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic key_in(input logic [7:0] code, input logic [47:0] keys);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (keys[j*8 +: 8] == code) hit = 1'b1;
        end
        return hit;
    endfunction

    // True when slot k repeats a code already seen in a lower slot, so that
    // duplicated keycodes within one report produce only one event.
    function automatic logic dup_before(input logic [47:0] keys, input logic [2:0] k);
        logic hit;
        logic [7:0] cur;
        hit = 1'b0;
        cur = key_at(keys, k);
        for (int j = 0; j < 6; j++) begin
            if (j < int'(k) && keys[j*8 +: 8] == cur) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic has_rollover(input logic [47:0] keys);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (keys[j*8 +: 8] >= 8'h01 && keys[j*8 +: 8] <= 8'h03) hit = 1'b1;
        end
        return hit;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q;
    logic [2:0]         idx_q;
    logic [7:0]         new_mod_q;
    logic [47:0]        new_keys_q;
    logic [7:0]         prev_mod_q;
    logic [47:0]        prev_keys_q;
    logic               busy_q;
    logic               overrun_q;

    logic [8:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   level_q;
    logic [FIFO_AW:0]   level_d;

    // ------------------------------------------------------------------
    // Incoming snapshot: a disconnected keyboard reads as all keys up.
    // ------------------------------------------------------------------
    logic [7:0]  in_mod;
    logic [47:0] in_keys;
    logic        in_rollover;

    always_comb begin
        in_mod      = kbd_connected ? kbd_modifiers : 8'h00;
        in_keys     = kbd_connected ? kbd_keycodes  : 48'h0;
        in_rollover = has_rollover(in_keys);
    end

    // ------------------------------------------------------------------
    // Candidate event for the current scan step
    // ------------------------------------------------------------------
    logic       cand_push;
    logic [7:0] cand_code;
    logic       cand_make;
    logic [7:0] cur_prev;
    logic [7:0] cur_new;

    always_comb begin
        cand_push = 1'b0;
        cand_code = 8'h00;
        cand_make = 1'b0;
        cur_prev  = key_at(prev_keys_q, idx_q);
        cur_new   = key_at(new_keys_q, idx_q);
        case (state_q)
            S_MOD: begin
                cand_push = new_mod_q[idx_q] != prev_mod_q[idx_q];
                cand_code = 8'hE0 + {5'b00000, idx_q};
                cand_make = new_mod_q[idx_q];
            end
            S_REL: begin
                cand_push = (cur_prev != 8'h00) && !key_in(cur_prev, new_keys_q)
                            && !dup_before(prev_keys_q, idx_q);
                cand_code = cur_prev;
                cand_make = 1'b0;
            end
            S_PRS: begin
                cand_push = (cur_new != 8'h00) && !key_in(cur_new, prev_keys_q)
                            && !dup_before(new_keys_q, idx_q);
                cand_code = cur_new;
                cand_make = 1'b1;
            end
            default: begin
                cand_push = 1'b0;
            end
        endcase
    end

    // Fullness uses the registered level only: a pop in the same cycle does
    // not make room, which keeps the push decision off the consumer path.
    logic fifo_full;
    logic push;
    logic pop;
    logic step_done;

    always_comb begin
        fifo_full = (level_q == DEPTH_L);
        push      = cand_push & ~fifo_full;
        step_done = ~cand_push | ~fifo_full;
        pop       = (level_q != '0) & evt_ready;
    end

    // ------------------------------------------------------------------
    // Diff FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_48m or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            new_mod_q   <= 8'h00;
            new_keys_q  <= 48'h0;
            prev_mod_q  <= 8'h00;
            prev_keys_q <= 48'h0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // Setting has priority over clearing.
            if (report_valid && (busy_q || in_rollover)) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (report_valid && !in_rollover) begin
                        new_mod_q  <= in_mod;
                        new_keys_q <= in_keys;
                        idx_q      <= 3'd0;
                        state_q    <= S_MOD;
                        busy_q     <= 1'b1;
                    end
                end
                S_MOD: begin
                    if (step_done) begin
                        if (idx_q == 3'd7) begin
                            idx_q   <= 3'd0;
                            state_q <= S_REL;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                S_REL: begin
                    if (step_done) begin
                        if (idx_q == 3'd5) begin
                            idx_q   <= 3'd0;
                            state_q <= S_PRS;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                S_PRS: begin
                    if (step_done) begin
                        if (idx_q == 3'd5) begin
                            idx_q       <= 3'd0;
                            state_q     <= S_IDLE;
                            busy_q      <= 1'b0;
                            prev_mod_q  <= new_mod_q;
                            prev_keys_q <= new_keys_q;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_48m or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk_48m) begin
        if (push) mem_q[wr_ptr_q] <= {cand_code, cand_make};
    end

    logic [8:0] head;

    always_comb begin
        head           = mem_q[rd_ptr_q];
        evt_valid      = (level_q != '0);
        evt_code       = evt_valid ? head[8:1] : 8'h00;
        evt_make       = evt_valid ? head[0]   : 1'b0;
        evt_level      = level_q;
        report_busy    = busy_q;
        report_overrun = overrun_q;
    end

endmodule

// File: tb/tb_hid_key_event_gen.sv
module tb_hid_key_event_gen;

    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = 4;

    logic               clk_48m = 1'b0;
    logic               rstn = 1'b0;
    logic               report_valid = 1'b0;
    logic               kbd_connected = 1'b0;
    logic [7:0]         kbd_modifiers = 8'h00;
    logic [47:0]        kbd_keycodes = 48'h0;
    logic               report_busy;
    logic               report_overrun;
    logic               overrun_clr = 1'b0;
    logic               evt_valid;
    logic               evt_ready = 1'b0;
    logic [7:0]         evt_code;
    logic               evt_make;
    logic [FIFO_AW:0]   evt_level;

    hid_key_event_gen #(.FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW)) dut (
        .clk_48m       (clk_48m),
        .rstn          (rstn),
        .report_valid  (report_valid),
        .kbd_connected (kbd_connected),
        .kbd_modifiers (kbd_modifiers),
        .kbd_keycodes  (kbd_keycodes),
        .report_busy   (report_busy),
        .report_overrun(report_overrun),
        .overrun_clr   (overrun_clr),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_code      (evt_code),
        .evt_make      (evt_make),
        .evt_level     (evt_level)
    );

    always #10 clk_48m = ~clk_48m;

    int checks = 0;
    int failures = 0;

    // Model state: last accepted report and the events it still owes.
    logic [7:0] m_prev_mod = 8'h00;
    logic [7:0] m_prev_keys [6] = '{default: 8'h00};
    logic [8:0] exp_q [$];
    logic [8:0] log_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Event list of a report: the diff rules stated as plain set arithmetic.
    task automatic model_report(input logic conn, input logic [7:0] mod, input logic [47:0] keys);
        logic [7:0] nm;
        logic [7:0] nk [6];
        bit seen;
        nm = conn ? mod : 8'h00;
        for (int k = 0; k < 6; k++) nk[k] = conn ? keys[k*8 +: 8] : 8'h00;
        for (int i = 0; i < 8; i++)
            if (nm[i] != m_prev_mod[i]) exp_q.push_back({8'hE0 + 8'(i), nm[i]});
        for (int k = 0; k < 6; k++) begin
            seen = 0;
            for (int j = 0; j < 6; j++) if (nk[j] == m_prev_keys[k]) seen = 1;
            for (int j = 0; j < k; j++) if (m_prev_keys[j] == m_prev_keys[k]) seen = 1;
            if (m_prev_keys[k] != 8'h00 && !seen) exp_q.push_back({m_prev_keys[k], 1'b0});
        end
        for (int k = 0; k < 6; k++) begin
            seen = 0;
            for (int j = 0; j < 6; j++) if (m_prev_keys[j] == nk[k]) seen = 1;
            for (int j = 0; j < k; j++) if (nk[j] == nk[k]) seen = 1;
            if (nk[k] != 8'h00 && !seen) exp_q.push_back({nk[k], 1'b1});
        end
        m_prev_mod = nm;
        for (int k = 0; k < 6; k++) m_prev_keys[k] = nk[k];
    endtask

    // Compare every popped event with the model's expected stream.
    always @(negedge clk_48m) begin
        if (rstn && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_event actual=%0h required=none", {evt_code, evt_make});
            end else begin
                chk("event_stream", {23'd0, evt_code, evt_make}, {23'd0, exp_q.pop_front()});
            end
            log_q.push_back({evt_code, evt_make});
        end
    end

    task automatic send(input logic conn, input logic [7:0] mod, input logic [47:0] keys,
                        input bit accept, input bit clr);
        @(posedge clk_48m); #1;
        report_valid  = 1'b1;
        kbd_connected = conn;
        kbd_modifiers = mod;
        kbd_keycodes  = keys;
        overrun_clr   = clr;
        if (accept) model_report(conn, mod, keys);
        @(posedge clk_48m); #1;
        report_valid = 1'b0;
        overrun_clr  = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_48m);
            if (!report_busy) return;
            n++;
        end
    endtask

    task automatic wait_drain(input string name, input int bound);
        for (int c = 0; c < bound; c++) begin
            @(negedge clk_48m);
            if (!report_busy && evt_level == 0) return;
        end
        checks++;
        failures++;
        $display("FAIL %s_timeout actual=level%0d required=0", name, evt_level);
    endtask

    task automatic pulse_clr();
        @(posedge clk_48m); #1;
        overrun_clr = 1'b1;
        @(posedge clk_48m); #1;
        overrun_clr = 1'b0;
    endtask

    int nb;
    int li;

    initial begin
        repeat (3) @(posedge clk_48m);
        #1 rstn = 1'b1;

        // Reset state
        @(negedge clk_48m);
        chk("rst_busy", report_busy, 0);
        chk("rst_overrun", report_overrun, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_make", evt_make, 0);
        chk("rst_level", evt_level, 0);

        // Single press, consumer stalled
        send(1, 8'h00, 48'h0000_0000_0004, 1, 0);
        count_busy(nb);
        chk("busy_cycles", nb, 20);
        @(negedge clk_48m);
        chk("a_level", evt_level, 1);
        chk("a_code", evt_code, 8'h04);
        chk("a_make", evt_make, 1);

        // Modifier + key change, consumer ready
        evt_ready = 1'b1;
        send(1, 8'h02, 48'h0000_0000_0005, 1, 0);
        wait_drain("b", 100);
        chk("log0", log_q[0], {8'h04, 1'b1});
        chk("log1", log_q[1], {8'hE1, 1'b1});
        chk("log2", log_q[2], {8'h04, 1'b0});
        chk("log3", log_q[3], {8'h05, 1'b1});

        // Fill the FIFO: each report toggles all 8 modifiers
        evt_ready = 1'b0;
        li = log_q.size();
        for (int r = 0; r < 6; r++) begin
            send(1, (r % 2 == 0) ? 8'hFD : 8'h02, 48'h0000_0000_0005, r < 3, 0);
            repeat (23) @(posedge clk_48m);
        end
        @(negedge clk_48m);
        chk("full_level", evt_level, 16);
        chk("full_busy", report_busy, 1);
        chk("full_overrun", report_overrun, 1);
        evt_ready = 1'b1;
        wait_drain("fill", 1000);
        chk("fill_events", log_q.size() - li, 24);
        chk("fill_pending", exp_q.size(), 0);
        pulse_clr();
        @(negedge clk_48m);
        chk("clr_overrun", report_overrun, 0);

        // Hold three keys, then disconnect
        send(1, 8'hFD, 48'h0000_0006_0504, 1, 0);
        wait_drain("hold", 100);
        li = log_q.size();
        send(0, 8'h55, 48'h0000_0000_1111, 1, 0);
        wait_drain("disc", 100);
        chk("disc_count", log_q.size() - li, 10);
        chk("disc_first", log_q[li], {8'hE0, 1'b0});
        chk("disc_last", log_q[li + 9], {8'h06, 1'b0});

        // Rollover report is dropped
        li = log_q.size();
        send(1, 8'h00, 48'h0101_0101_0101, 0, 0);
        @(negedge clk_48m);
        chk("roll_busy", report_busy, 0);
        chk("roll_overrun", report_overrun, 1);
        pulse_clr();
        @(negedge clk_48m);
        chk("roll_clr", report_overrun, 0);
        send(1, 8'h00, 48'h0000_0003_0000, 0, 1);
        @(negedge clk_48m);
        chk("set_wins", report_overrun, 1);
        pulse_clr();
        @(negedge clk_48m);
        chk("roll_clr2", report_overrun, 0);
        chk("roll_events", log_q.size() - li, 0);

        // Duplicates and reorder
        li = log_q.size();
        send(1, 8'h00, 48'h0000_0000_0707, 1, 0);
        wait_drain("dup", 100);
        chk("dup_count", log_q.size() - li, 1);
        chk("dup_evt", log_q[li], {8'h07, 1'b1});
        li = log_q.size();
        send(1, 8'h00, 48'h0000_0000_0700, 1, 0);
        wait_drain("reord", 100);
        repeat (3) @(negedge clk_48m);
        chk("reord_count", log_q.size() - li, 0);

        // Reset mid-scan clears everything
        send(1, 8'h00, 48'h0000_0000_0008, 1, 0);
        repeat (3) @(posedge clk_48m);
        #1 rstn = 1'b0;
        exp_q.delete();
        m_prev_mod = 8'h00;
        for (int k = 0; k < 6; k++) m_prev_keys[k] = 8'h00;
        @(negedge clk_48m);
        chk("mrst_busy", report_busy, 0);
        chk("mrst_level", evt_level, 0);
        @(posedge clk_48m); #1 rstn = 1'b1;
        li = log_q.size();
        send(1, 8'h00, 48'h0000_0000_0008, 1, 0);
        wait_drain("mrst", 100);
        chk("mrst_count", log_q.size() - li, 1);
        chk("mrst_evt", log_q[li], {8'h08, 1'b1});
        chk("end_pending", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
